// File: rtl/sram_fifo_loader.sv
// Strided SRAM-to-FIFO loader: issues reads from a 1-cycle-latency scratch SRAM
// and pushes each returned word into the FIFO, absorbing a full stall with a skid register.
module sram_fifo_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              abort,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [ADDR_WIDTH-1:0]             stride,
  input  logic [CNT_WIDTH-1:0]              count,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_ren,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0]   mem_rdata,
  output logic                              fifo_wen,
  output logic [PAR_WRITE*DATA_WIDTH-1:0]   fifo_din,
  input  logic                              fifo_full
);

  localparam int unsigned WORD_W = PAR_WRITE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  written_q;
  logic [WORD_W-1:0]     skid_q;
  logic                  skid_valid_q;
  logic                  inflight_q;

  logic                  issue;
  logic                  wen;
  logic [WORD_W-1:0]     din;
  logic                  skid_load;

  // Next state, read issue and write-path selection
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    wen       = 1'b0;
    din       = '0;
    skid_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // No new read while the skid is occupied or a returning word is about to be stalled
          issue = (issued_q < count_q) && !skid_valid_q && !(inflight_q && fifo_full);
          if (skid_valid_q && !fifo_full) begin
            wen = 1'b1;
            din = skid_q;
          end else if (inflight_q && !fifo_full) begin
            wen = 1'b1;
            din = mem_rdata;
          end else if (inflight_q && fifo_full) begin
            skid_load = 1'b1;
          end
          if ((written_q + CNT_WIDTH'(wen)) == count_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, transfer counters, address accumulator and skid register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      written_q    <= '0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == IDLE && start) begin
        addr_q    <= base_addr;
        stride_q  <= stride;
        count_q   <= count;
        issued_q  <= '0;
        written_q <= '0;
      end
      if (issue) begin
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + CNT_WIDTH'(1);
      end
      if (wen) written_q <= written_q + CNT_WIDTH'(1);
      if (skid_load) begin
        skid_q       <= mem_rdata;
        skid_valid_q <= 1'b1;
      end else if (wen && skid_valid_q) begin
        skid_valid_q <= 1'b0;
      end
      if (abort && state_q != IDLE) begin
        skid_valid_q <= 1'b0;
        inflight_q   <= 1'b0;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mem_ren  = issue;
  assign mem_addr = addr_q;
  assign fifo_wen = wen;
  assign fifo_din = din;

endmodule

// File: tb/tb_sram_fifo_loader.sv
// Directed bench for sram_fifo_loader: SRAM model, forced or modelled FIFO full,
// event logs per cycle relative to the start pulse.
module tb_sram_fifo_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  stride = '0;
  logic [7:0]  count = '0;
  logic        busy, done, mem_ren, fifo_wen, fifo_full;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] fifo_din;

  logic        full_force = 1'b0;
  logic        fifo_mode = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;

  int ren_a[$], ren_c[$], wen_d[$], wen_c[$], done_c[$], busy_c[$], pop_d[$];
  int ren_skid = 0, ovf = 0, skid_caps = 0, inv_err = 0;
  logic skid_prev = 1'b0;

  logic [15:0] fmem [4];
  logic [1:0]  fwp = '0, frp = '0;
  logic [2:0]  fcnt = '0;
  logic        rd_en = 1'b0;

  sram_fifo_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .stride(stride), .count(count),
    .busy(busy), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] wfun(input logic [7:0] a);
    return {a, a ^ 8'h5A};
  endfunction

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  always @(posedge clk) if (mem_ren) mem_rdata <= wfun(mem_addr);

  assign fifo_full = fifo_mode ? (fcnt == 3'd4) : full_force;

  // Depth-4 FIFO model with a reader that starts once the FIFO first fills
  always @(posedge clk) begin : fifo_model
    logic push, pop;
    if (fifo_mode) begin
      push = fifo_wen && !fifo_full;
      pop  = rd_en && (fcnt != 3'd0);
      if (push) begin
        fmem[fwp] <= fifo_din;
        fwp <= fwp + 2'd1;
      end
      if (pop) begin
        pop_d.push_back(int'(fmem[frp]));
        frp <= frp + 2'd1;
      end
      fcnt <= fcnt + 3'(push) - 3'(pop);
      if (fcnt == 3'd4) rd_en <= 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    int rel;
    rel = cyc - t0;
    if (rstn) begin
      if (mem_ren) begin
        ren_a.push_back(int'(mem_addr));
        ren_c.push_back(rel);
        if (dut.skid_valid_q) ren_skid++;
      end
      if (fifo_wen) begin
        wen_d.push_back(int'(fifo_din));
        wen_c.push_back(rel);
        if (fifo_full) ovf++;
      end
      if (done) done_c.push_back(rel);
      if (busy) busy_c.push_back(rel);
      if (dut.skid_valid_q && !skid_prev) skid_caps++;
      skid_prev = dut.skid_valid_q;
      a_inv: assert (!(dut.skid_valid_q && dut.inflight_q)) else inv_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer: start in rel cycle 0, full forced in [flo,fhi], optional abort / restart pulse
  task automatic run(input logic [7:0] b, input logic [7:0] s, input logic [7:0] n,
                     input int flo, input int fhi, input int ab_at, input int rs_at,
                     input int ncyc);
    ren_a.delete(); ren_c.delete(); wen_d.delete(); wen_c.delete();
    done_c.delete(); busy_c.delete(); pop_d.delete();
    skid_caps = 0;
    base_addr  = b;
    stride     = s;
    count      = n;
    start      = 1'b1;
    t0         = cyc;
    full_force = (flo <= 0 && fhi >= 0);
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      start = (i == rs_at);
      if (i == rs_at) begin
        base_addr = 8'h90;
        count     = 8'd7;
      end
      abort      = (i == ab_at);
      full_force = (i >= flo && i <= fhi);
    end
    start = 1'b0;
    abort = 1'b0;
    full_force = 1'b0;
  endtask

  initial begin
    logic [7:0] wa [3];
    wa[0] = 8'hFC; wa[1] = 8'hFF; wa[2] = 8'h02;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_wen", 32'(fifo_wen), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic run
    run(8'h10, 8'd1, 8'd4, -1, -1, -1, -1, 10);
    chk("b_nren", 32'(ren_a.size()), 32'd4);
    foreach (ren_a[i]) begin
      chk("b_addr", 32'(ren_a[i]), 32'h10 + 32'(i));
      chk("b_rcyc", 32'(ren_c[i]), 32'(i + 1));
    end
    chk("b_nwen", 32'(wen_d.size()), 32'd4);
    foreach (wen_d[i]) begin
      chk("b_data", 32'(wen_d[i]), 32'(wfun(8'(8'h10 + i))));
      chk("b_wcyc", 32'(wen_c[i]), 32'(i + 2));
    end
    chk("b_ndone", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) chk("b_dcyc", 32'(done_c[0]), 32'd6);
    chk("b_nbusy", 32'(busy_c.size()), 32'd6);
    if (busy_c.size() > 0) chk("b_bfirst", 32'(busy_c[0]), 32'd1);

    // Strided run with address wrap
    run(8'hFC, 8'd3, 8'd3, -1, -1, -1, -1, 10);
    chk("w_nren", 32'(ren_a.size()), 32'd3);
    foreach (ren_a[i]) if (i < 3) chk("w_addr", 32'(ren_a[i]), 32'(wa[i]));
    chk("w_nwen", 32'(wen_d.size()), 32'd3);
    foreach (wen_d[i]) if (i < 3) chk("w_data", 32'(wen_d[i]), 32'(wfun(wa[i])));
    chk("w_ndone", 32'(done_c.size()), 32'd1);

    // Backpressure: full in cycles 3-5
    run(8'h80, 8'd1, 8'd6, 3, 5, -1, -1, 16);
    chk("bp_caps", 32'(skid_caps), 32'd1);
    chk("bp_nwen", 32'(wen_d.size()), 32'd6);
    foreach (wen_d[i]) chk("bp_data", 32'(wen_d[i]), 32'(wfun(8'(8'h80 + i))));
    chk("bp_wen35", 32'(count_in(wen_c, 3, 5)), 32'd0);
    chk("bp_ren36", 32'(count_in(ren_c, 3, 6)), 32'd0);
    if (wen_c.size() == 6) chk("bp_wlast", 32'(wen_c[5]), 32'd11);
    chk("bp_ndone", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) chk("bp_dcyc", 32'(done_c[0]), 32'd12);

    // Real FIFO model, depth 4
    fifo_mode = 1'b1;
    run(8'h40, 8'd2, 8'd10, -1, -1, -1, -1, 40);
    fifo_mode = 1'b0;
    chk("f_npop", 32'(pop_d.size()), 32'd10);
    foreach (pop_d[i]) chk("f_data", 32'(pop_d[i]), 32'(wfun(8'(8'h40 + 2 * i))));
    chk("f_ndone", 32'(done_c.size()), 32'd1);

    // Abort after two writes
    run(8'h20, 8'd1, 8'd8, -1, -1, 4, -1, 8);
    chk("a_nwen", 32'(wen_d.size()), 32'd2);
    chk("a_ren4", 32'(count_in(ren_c, 4, 4)), 32'd0);
    chk("a_ndone", 32'(done_c.size()), 32'd0);
    chk("a_nbusy", 32'(busy_c.size()), 32'd4);
    run(8'h30, 8'd1, 8'd2, -1, -1, -1, -1, 6);
    chk("a2_nwen", 32'(wen_d.size()), 32'd2);
    foreach (wen_d[i]) chk("a2_data", 32'(wen_d[i]), 32'(wfun(8'(8'h30 + i))));
    chk("a2_ndone", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) chk("a2_dcyc", 32'(done_c[0]), 32'd4);

    // count = 0
    run(8'h00, 8'd1, 8'd0, -1, -1, -1, -1, 4);
    chk("z_nren", 32'(ren_a.size()), 32'd0);
    chk("z_nwen", 32'(wen_d.size()), 32'd0);
    chk("z_ndone", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) chk("z_dcyc", 32'(done_c[0]), 32'd1);

    // start while busy is ignored
    run(8'h50, 8'd1, 8'd4, -1, -1, -1, 2, 10);
    chk("r_nren", 32'(ren_a.size()), 32'd4);
    foreach (ren_a[i]) chk("r_addr", 32'(ren_a[i]), 32'h50 + 32'(i));
    chk("r_nwen", 32'(wen_d.size()), 32'd4);
    chk("r_ndone", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) chk("r_dcyc", 32'(done_c[0]), 32'd6);

    chk("inv_skid_inflight", 32'(inv_err), 32'd0);
    chk("ren_while_skid", 32'(ren_skid), 32'd0);
    chk("wen_while_full", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fifo_loader.md
Name: sram_fifo_loader

Overview:
- Upstream feeder for the team's circular FIFO buffer.
- Reads a strided run of words from a local scratch SRAM, which has 1-cycle read latency, and pushes each word into the FIFO write port.
- Holds a one-entry skid register, so no word is lost when the FIFO reports full while a read is in flight.
- Controlled by the layer sequencer through a start/done handshake.

Parameters:
- DATA_WIDTH, 16, element width; matches the FIFO DATA_WIDTH.
- PAR_WRITE, 1, elements per SRAM word and per FIFO write; word width is PAR_WRITE*DATA_WIDTH.
- ADDR_WIDTH, 8, SRAM address width.
- CNT_WIDTH, 8, width of the word-count field.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current transfer.
- base_addr  input  ADDR_WIDTH  first SRAM address; latched on start.
- stride  input  ADDR_WIDTH  address increment between words; latched on start.
- count  input  CNT_WIDTH  number of words to move; latched on start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the transfer completes.
- mem_ren  output  1  SRAM read enable.
- mem_addr  output  ADDR_WIDTH  SRAM read address.
- mem_rdata  input  PAR_WRITE*DATA_WIDTH  SRAM data, valid the cycle after mem_ren.
- fifo_wen  output  1  FIFO write enable.
- fifo_din  output  PAR_WRITE*DATA_WIDTH  FIFO write data.
- fifo_full  input  1  combinational full flag from the FIFO.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State IDLE; all counters and the address register cleared.
  - skid_valid=0, inflight=0.
  - busy, done, mem_ren, fifo_wen = 0; fifo_din = 0.
- States:
  - IDLE: on start, latch base_addr/stride/count, set issued=0 and written=0. Go to RUN if count!=0, else go to DONE.
  - RUN: issue reads and write words as described below. When written reaches count, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read issue (RUN, combinational):
  - mem_ren = (issued<count) & !skid_valid & !(inflight & fifo_full).
  - mem_addr = base + issued*stride, computed as a running sum that wraps modulo 2^ADDR_WIDTH.
  - Each issue increments issued; inflight <= mem_ren.
- Write path, evaluated each cycle:
  - skid_valid & !fifo_full: fifo_wen=1, fifo_din=skid; skid_valid <= 0.
  - Otherwise, inflight & !fifo_full: fifo_wen=1, fifo_din=mem_rdata.
  - Otherwise, inflight & fifo_full: skid <= mem_rdata, skid_valid <= 1, fifo_wen=0.
  - fifo_wen is never asserted while fifo_full=1.
  - Each fifo_wen increments written.
- Invariant: skid_valid and inflight are never both 1. This follows from the issue rule, and the bench must assert it.
- Throughput and latency:
  - 1 word/cycle while the FIFO is not full.
  - start in cycle 0 → first mem_ren in cycle 1 → first fifo_wen in cycle 2.
  - Last fifo_wen in cycle N → done in cycle N+1.
- Order: words enter the FIFO in address order with no duplicates or drops, including across any sequence of full/not-full transitions.
- start while busy is ignored; latched parameters are unchanged.
- abort (any state other than IDLE):
  - Next state IDLE; skid_valid and inflight cleared; no done pulse.
  - mem_ren and fifo_wen are 0 in the abort cycle.
  - abort and rstn=0 in the same cycle: reset wins, with the same result.
- count=0 → IDLE, DONE, IDLE; no mem_ren or fifo_wen; done one cycle after start.
- The address counter wraps; base=0xFE, stride=1 produces 0xFE, 0xFF, 0x00.

Test Plan:
- Basic run: base=0x10, stride=1, count=4, fifo_full=0 throughout.
  - mem_ren in cycles 1-4 with addresses 0x10-0x13.
  - fifo_wen in cycles 2-5 with the matching data.
  - done in cycle 6; busy high in cycles 1-6.
- Strided run with wrap: base=0xFC, stride=3, count=3.
  - Addresses 0xFC, 0xFF, 0x02; 3 writes; one done pulse.
- Backpressure: count=6, fifo_full forced high in cycles 3-5.
  - Exactly one word is captured in the skid; no mem_ren while skid_valid.
  - No fifo_wen in cycles 3-5.
  - FIFO receives all 6 words in order; done follows the last write.
- Real-FIFO integration: loader drives the FIFO (DEPTH=4), count=10, reader idle until full, then ren=1.
  - The 10 words are read out in order; the FIFO never overflows.
- abort after 2 writes of a count=8 run.
  - busy falls next cycle; no done pulse.
  - A subsequent start with count=2 completes normally.
- count=0, and start pulsed while busy.
  - count=0 gives a done pulse with no memory or FIFO traffic.
  - A start while busy leaves the transfer unchanged.
